s2p_frame_controller: RTL and testbench
=======================================

// Module: s2p_frame_controller
// PURPOSE
//   Sequences the 8-stage byte shift chain that assembles 64-bit frames from serial bytes.
//   Two byte sources compete for the chain. Round-robin arbitration, locked for a whole frame.
//   Drives the chain's shift enable, data byte and sync clear. Flags a completed frame downstream.
//   Holds the chain with a valid/ready handshake until the frame is consumed.
// PARAMETERS
//   BYTES_PER_FRAME  8    bytes accepted per frame (2..255); equals the chain depth
//   TIMEOUT_CYCLES   255  consecutive idle cycles of the granted source mid-frame before abort (1..65535)
// PORTS
//   clk          in   1  single clock; all state changes on rising edge
//   reset        in   1  asynchronous, active-low reset
//   req0_valid   in   1  source 0 byte valid
//   req0_data    in   8  source 0 byte
//   req0_ready   out  1  source 0 byte accepted when valid&ready
//   req1_valid   in   1  source 1 byte valid
//   req1_data    in   8  source 1 byte
//   req1_ready   out  1  source 1 byte accepted when valid&ready
//   shift_en     out  1  chain shifts in shift_data this edge
//   shift_data   out  8  byte presented to chain stage 0
//   shift_clr    out  1  one-cycle sync clear of all chain stages
//   frame_valid  out  1  chain holds a complete frame
//   frame_ready  in   1  downstream consumes the frame when valid&ready
//   frame_src    out  1  source that produced the held/current frame
//   frame_abort  out  1  one-cycle pulse: partial frame discarded on timeout
//   busy         out  1  high in every state except IDLE
// BEHAVIOUR
//   Reset (reset=0, async):
//     - state=IDLE, byte count=0, idle count=0, RR pointer prefers source 0.
//     - All outputs 0; shift_data=8'h00.
//   IDLE:
//     - Both readys are 0.
//     - If any req valid: grant the requester the pointer prefers, else the only valid one.
//     - Register the grant; next state COLLECT. Grant needs 1 cycle; no byte is accepted in IDLE.
//   COLLECT:
//     - Granted ready=1; the other ready=0.
//     - shift_en = granted valid; shift_data = granted data, combinational mux.
//     - shift_data=8'h00 when shift_en=0.
//     - Each accept increments the byte count and zeroes the idle count.
//     - On the accept taking count to BYTES_PER_FRAME: next state HOLD, count cleared.
//     - Each cycle the granted valid is low, idle count increments.
//     - When idle count reaches TIMEOUT_CYCLES:
//       - Same cycle: shift_clr=1 and frame_abort=1.
//       - Next state IDLE; pointer moves to the other source.
//     - Timeout applies even at count 0.
//   HOLD:
//     - frame_valid=1 and frame_src=grant, stable until accepted.
//     - Both readys=0 and shift_en=0, so the chain is frozen.
//     - On frame_valid & frame_ready: next state IDLE; pointer moves to the other source.
//     - frame_valid drops the following cycle.
//     - No shift_clr on a normal hand-off; the next frame overwrites every stage.
//   Latency:
//     - frame_valid rises the cycle after the last byte is accepted.
//     - Minimum frame period is BYTES_PER_FRAME + 2 cycles (IDLE + collect + HOLD).
//   Simultaneous events:
//     - Non-granted valid is ignored until a later IDLE.
//     - Timeout and accept cannot coincide, because an accept zeroes the idle count.
//   Reset mid-frame: state and counts cleared at once; no frame_valid or frame_abort is produced.
//   The chain contents are cleared by its own reset, not by this block.
// TESTING
//   T1 reset:
//     - Assert reset=0 mid-COLLECT.
//     - Required: all outputs 0 immediately, state IDLE; after release, req0 wins the first tie.
//   T2 single source:
//     - req0 streams 8'h01..8'h08 back-to-back.
//     - Required: 8 shift_en pulses carrying 01..08 in order.
//     - frame_valid=1 with frame_src=0 one cycle after the 8th accept.
//   T3 arbitration:
//     - req0 and req1 both valid continuously, frame_ready=1.
//     - Required: frames alternate src 0,1,0,1; the loser's ready stays 0 during the other's frame.
//   T4 backpressure:
//     - frame_ready=0 for 5 cycles in HOLD.
//     - Required: frame_valid held, shift_en=0, both readys 0; IDLE the cycle after frame_ready=1.
//   T5 timeout:
//     - TIMEOUT_CYCLES=4; req1 sends 3 bytes, then valid=0.
//     - Required: on the 4th idle cycle shift_clr=1 and frame_abort=1; IDLE next; next tie grants req0.
//   T6 stall:
//     - req0 valid toggles 1,0,1,0 across the frame.
//     - Required: exactly 8 accepts, no abort; idle count never exceeds 1.

Source files
------------

// File: rtl/s2p_frame_controller.sv
// Sequencer for an 8-stage serial-to-parallel byte chain.
// Two sources are arbitrated round-robin, and a grant is held for a whole frame.
module s2p_frame_controller #(
    parameter int BYTES_PER_FRAME = 8,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       shift_en,
    output logic [7:0] shift_data,
    output logic       shift_clr,
    output logic       frame_valid,
    input  logic       frame_ready,
    output logic       frame_src,
    output logic       frame_abort,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

    localparam logic [7:0]  LAST_BYTE = 8'(BYTES_PER_FRAME - 1);
    localparam logic [15:0] LAST_IDLE = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_reg, state_next;
    logic        grant_reg, grant_next;
    logic        ptr_reg, ptr_next;
    logic [7:0]  byte_cnt_reg, byte_cnt_next;
    logic [15:0] idle_cnt_reg, idle_cnt_next;
    logic        gnt_valid;
    logic [7:0]  gnt_data;

    assign gnt_valid = grant_reg ? req1_valid : req0_valid;
    assign gnt_data  = grant_reg ? req1_data  : req0_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            grant_reg    <= 1'b0;
            ptr_reg      <= 1'b0;
            byte_cnt_reg <= '0;
            idle_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            grant_reg    <= grant_next;
            ptr_reg      <= ptr_next;
            byte_cnt_reg <= byte_cnt_next;
            idle_cnt_reg <= idle_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        grant_next    = grant_reg;
        ptr_next      = ptr_reg;
        byte_cnt_next = byte_cnt_reg;
        idle_cnt_next = idle_cnt_reg;
        req0_ready    = 1'b0;
        req1_ready    = 1'b0;
        shift_en      = 1'b0;
        shift_data    = 8'h00;
        shift_clr     = 1'b0;
        frame_valid   = 1'b0;
        frame_src     = 1'b0;
        frame_abort   = 1'b0;
        busy          = 1'b0;

        case (state_reg)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    // On a tie the pointer decides; otherwise the lone requester wins.
                    grant_next    = (req0_valid && req1_valid) ? ptr_reg : req1_valid;
                    state_next    = COLLECT;
                    byte_cnt_next = '0;
                    idle_cnt_next = '0;
                end
            end
            COLLECT: begin
                busy       = 1'b1;
                frame_src  = grant_reg;
                req0_ready = ~grant_reg;
                req1_ready = grant_reg;
                if (gnt_valid) begin
                    shift_en      = 1'b1;
                    shift_data    = gnt_data;
                    idle_cnt_next = '0;
                    if (byte_cnt_reg == LAST_BYTE) begin
                        byte_cnt_next = '0;
                        state_next    = HOLD;
                    end else begin
                        byte_cnt_next = byte_cnt_reg + 8'd1;
                    end
                end else if (idle_cnt_reg == LAST_IDLE) begin
                    // This is the idle cycle that reaches the limit: drop the partial frame now.
                    shift_clr     = 1'b1;
                    frame_abort   = 1'b1;
                    state_next    = IDLE;
                    ptr_next      = ~grant_reg;
                    byte_cnt_next = '0;
                    idle_cnt_next = '0;
                end else begin
                    idle_cnt_next = idle_cnt_reg + 16'd1;
                end
            end
            HOLD: begin
                busy        = 1'b1;
                frame_valid = 1'b1;
                frame_src   = grant_reg;
                if (frame_ready) begin
                    state_next = IDLE;
                    ptr_next   = ~grant_reg;
                end
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_s2p_frame_controller.sv
// Randomized scoreboard bench for s2p_frame_controller.
// The frame-level model predicts per-cycle events, and a monitor compares them against the DUT.
module tb_s2p_frame_controller;
    localparam int BPF = 8;
    localparam int TO  = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
    logic       req0_ready, req1_ready;
    logic       shift_en, shift_clr, frame_valid, frame_src, frame_abort, busy;
    logic [7:0] shift_data;
    logic       frame_ready = 1'b0;

    s2p_frame_controller #(.BYTES_PER_FRAME(BPF), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .shift_en(shift_en), .shift_data(shift_data), .shift_clr(shift_clr),
        .frame_valid(frame_valid), .frame_ready(frame_ready), .frame_src(frame_src),
        .frame_abort(frame_abort), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [14:0] vec;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] q0[$], q1[$];
    int         n_cmp = 0, n_fail = 0;

    // Frame-level reference state: the owner of the current frame (-1 means none),
    // bytes taken so far, the current quiet run, and the preferred source.
    int m_owner = -1, m_ptr = 0, m_got = 0, m_quiet = 0;

    // Event layout: kind(0 shift,1 abort,2 hold-wait,3 hold-take), src, data, r0, r1, clr, abort
    function automatic logic [14:0] pack(logic [1:0] k, logic s, logic [7:0] d,
                                         logic r0, logic r1, logic clr, logic ab);
        return {k, s, d, r0, r1, clr, ab};
    endfunction

    task automatic push_ev(input logic [14:0] v);
        ev_t e;
        e.cyc = cyc;
        e.vec = v;
        exp_q.push_back(e);
    endtask

    task automatic release_frame();
        m_ptr   = 1 - m_owner;
        m_owner = -1;
        m_got   = 0;
        m_quiet = 0;
    endtask

    task automatic model_step(input logic v0, input logic v1, input logic [7:0] d0,
                              input logic [7:0] d1, input logic fr,
                              output logic a0, output logic a1);
        logic s, vv;
        logic [7:0] dd;
        a0 = 1'b0;
        a1 = 1'b0;
        if (m_owner < 0) begin
            if (v0 || v1) m_owner = (v0 && v1) ? m_ptr : (v1 ? 1 : 0);
        end else begin
            s = (m_owner == 1);
            if (m_got == BPF) begin
                push_ev(pack({1'b1, fr}, s, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
                if (fr) release_frame();
            end else begin
                vv = s ? v1 : v0;
                dd = s ? d1 : d0;
                if (vv) begin
                    push_ev(pack(2'd0, s, dd, !s, s, 1'b0, 1'b0));
                    if (s) a1 = 1'b1; else a0 = 1'b1;
                    m_got++;
                    m_quiet = 0;
                end else begin
                    m_quiet++;
                    if (m_quiet == TO) begin
                        push_ev(pack(2'd1, s, 8'h00, !s, s, 1'b1, 1'b1));
                        release_frame();
                    end
                end
            end
        end
    endtask

    task automatic drive_step(input bit g0, input bit g1, input bit fr);
        logic v0, v1, a0, a1;
        logic [7:0] d0, d1;
        v0 = g0 && (q0.size() > 0);
        v1 = g1 && (q1.size() > 0);
        d0 = v0 ? q0[0] : 8'($urandom);
        d1 = v1 ? q1[0] : 8'($urandom);
        req0_valid = v0; req0_data = d0;
        req1_valid = v1; req1_data = d1;
        frame_ready = fr;
        model_step(v0, v1, d0, d1, fr, a0, a1);
        if (a0) void'(q0.pop_front());
        if (a1) void'(q1.pop_front());
    endtask

    task automatic cycle(input bit g0, input bit g1, input bit fr);
        @(posedge clk);
        #1;
        drive_step(g0, g1, fr);
    endtask

    task automatic fill(input int which, input int n);
        for (int i = 0; i < n; i++) begin
            if (which == 0) q0.push_back(8'($urandom));
            else            q1.push_back(8'($urandom));
        end
    endtask

    task automatic settle();
        q0.delete();
        q1.delete();
        repeat (BPF + TO + 2) cycle(1'b0, 1'b0, 1'b1);
    endtask

    task automatic check_reset_outputs(input string name);
        logic [15:0] outs;
        outs = {req0_ready, req1_ready, shift_en, shift_data, shift_clr,
                frame_valid, frame_src, frame_abort, busy};
        n_cmp++;
        if (outs !== 16'h0000) begin
            n_fail++;
            $display("FAIL %s outputs actual=%h required=0000", name, outs);
        end
    endtask

    // Monitor: pops the expected event for each cycle in which the DUT presents one.
    initial begin
        logic        present;
        logic [1:0]  kind;
        logic [14:0] act;
        ev_t         e;
        forever begin
            @(negedge clk);
            if (reset) begin
                n_cmp++;
                if (!shift_en && shift_data !== 8'h00) begin
                    n_fail++;
                    $display("FAIL idle_data cyc=%0d actual=%h required=00", cyc, shift_data);
                end
                while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                    e = exp_q.pop_front();
                    n_cmp++;
                    n_fail++;
                    $display("FAIL missing_event cyc=%0d actual=none required=%h", e.cyc, e.vec);
                end
                present = shift_en | frame_abort | shift_clr | frame_valid;
                kind = shift_en ? 2'd0 : ((frame_abort | shift_clr) ? 2'd1 : {1'b1, frame_ready});
                act = pack(kind, frame_src, shift_data, req0_ready, req1_ready, shift_clr, frame_abort);
                if (present) begin
                    n_cmp++;
                    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                        e = exp_q.pop_front();
                        if (act !== e.vec) begin
                            n_fail++;
                            $display("FAIL event cyc=%0d actual=%h required=%h", cyc, act, e.vec);
                        end
                    end else begin
                        n_fail++;
                        $display("FAIL unexpected_event cyc=%0d actual=%h required=none", cyc, act);
                    end
                end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                    e = exp_q.pop_front();
                    n_cmp++;
                    n_fail++;
                    $display("FAIL missing_event cyc=%0d actual=none required=%h", cyc, e.vec);
                end
            end
        end
    end

    initial begin
        // Power-on reset
        #2 reset = 1'b0;
        #1 check_reset_outputs("por");
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        drive_step(1'b0, 1'b0, 1'b1);

        // Single source streaming 01..08
        for (int i = 1; i <= BPF; i++) q0.push_back(8'(i));
        repeat (BPF + 4) cycle(1'b1, 1'b0, 1'b1);
        settle();

        // Both sources continuously valid: frames should alternate
        fill(0, 4 * BPF);
        fill(1, 4 * BPF);
        repeat (6 * (BPF + 2)) cycle(1'b1, 1'b1, 1'b1);
        settle();

        // Backpressure in HOLD
        fill(0, BPF);
        repeat (BPF + 1 + 5) cycle(1'b1, 1'b0, 1'b0);
        repeat (2) cycle(1'b1, 1'b0, 1'b1);
        settle();

        // Timeout after 3 bytes from source 1, then a tie
        fill(1, 3);
        repeat (TO + 6) cycle(1'b0, 1'b1, 1'b1);
        fill(0, BPF);
        fill(1, BPF);
        repeat (BPF + 4) cycle(1'b1, 1'b1, 1'b1);
        settle();

        // Stall: valid toggles through the frame
        fill(0, BPF);
        for (int i = 0; i < 3 * BPF; i++) cycle(i % 2 == 0, 1'b0, 1'b1);
        settle();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if (q0.size() < 4) fill(0, BPF);
            if (q1.size() < 4) fill(1, BPF);
            cycle(($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 2) == 0);
        end
        settle();

        // Reset in the middle of a frame
        fill(0, BPF);
        repeat (4) cycle(1'b1, 1'b0, 1'b1);
        @(posedge clk);
        #1 reset = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1 check_reset_outputs("midframe_reset");
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        m_owner = -1; m_ptr = 0; m_got = 0; m_quiet = 0;
        fill(0, BPF);
        fill(1, BPF);
        drive_step(1'b1, 1'b1, 1'b1);
        repeat (2 * (BPF + 2)) cycle(1'b1, 1'b1, 1'b1);
        settle();

        repeat (2) @(posedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain leftover=%0d required=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
